fft8_frame_ctrl: RTL and testbench

Frame sequencer for the 8-point FFT datapath (three registered butterfly stages).
- Collects 8 serial samples over a valid/ready stream and presents them in parallel to the datapath inputs a0..a7.
- Waits the datapath pipeline latency, then captures the 8 results.
- Streams the results back out serially with backpressure and a last-beat flag.

---
 rtl/fft8_frame_ctrl.sv | 102 ++++++++++
 tb/tb_fft8_frame_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft8_frame_ctrl.sv
// Frame sequencer for the 8-point FFT datapath: serial load, pipeline wait, serial unload.
// Define FFT8_FRAME_CTRL_BITREV_EN to emit results in bit-reversed index order.
module fft8_frame_ctrl #(
  parameter int N        = 4,
  parameter int PIPE_LAT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2**N-1:0]     in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [8*(2**N)-1:0] fft_a,
  output logic                fft_start,
  input  logic [8*(2**N)-1:0] fft_s,
  output logic [2**N-1:0]     out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                frame_done,
  output logic [7:0]          frame_cnt
);

  localparam int W   = 2**N;
  localparam int WCW = $clog2(PIPE_LAT + 2);

  typedef enum logic [1:0] {LOAD, WAIT, UNLOAD} state_t;

  state_t           state, state_nxt;
  logic [2:0]       in_cnt, out_idx;
  logic [WCW-1:0]   wait_cnt;
  logic [8*W-1:0]   result;
  logic             accept, xfer, last_in, last_out, wait_done;

  function automatic logic [2:0] order(input logic [2:0] i);
`ifdef FFT8_FRAME_CTRL_BITREV_EN
    return {i[0], i[1], i[2]};
`else
    return i;
`endif
  endfunction

  // in_ready is gated by rst so every output reads 0 while reset is held
  assign in_ready  = (state == LOAD) && !rst;
  assign out_valid = (state == UNLOAD);
  assign out_last  = out_valid && (out_idx == 3'd7);
  assign out_data  = result[int'(order(out_idx))*W +: W];

  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign last_in   = accept && (in_cnt == 3'd7);
  assign last_out  = xfer && (out_idx == 3'd7);
  assign wait_done = (state == WAIT) && (wait_cnt == WCW'(PIPE_LAT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (last_in)   state_nxt = WAIT;
      WAIT:    if (wait_done) state_nxt = UNLOAD;
      UNLOAD:  if (last_out)  state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // fft_a is the input buffer itself, so it mirrors loads and holds through WAIT/UNLOAD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt     <= '0;
      wait_cnt   <= '0;
      out_idx    <= '0;
      fft_a      <= '0;
      result     <= '0;
      fft_start  <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      fft_start  <= last_in;
      frame_done <= last_out;
      if (accept) begin
        fft_a[int'(in_cnt)*W +: W] <= in_data;
        in_cnt <= in_cnt + 3'd1;
      end
      if (state == WAIT) begin
        if (wait_done) begin
          result   <= fft_s;
          wait_cnt <= '0;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end
      if (xfer) begin
        out_idx <= out_idx + 3'd1;
        if (out_idx == 3'd7) frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// Directed bench for fft8_frame_ctrl with an identity datapath of PIPE_LAT registers.
module tb_fft8_frame_ctrl;

  localparam int N        = 4;
  localparam int W        = 16;
  localparam int PIPE_LAT = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [8*W-1:0] fft_a;
  logic           fft_start;
  logic [8*W-1:0] fft_s;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;
  logic           frame_done;
  logic [7:0]     frame_cnt;

  always #5 clk = ~clk;

  fft8_frame_ctrl #(.N(N), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .fft_a(fft_a), .fft_start(fft_start), .fft_s(fft_s),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  logic [8*W-1:0] p1, p2, p3;
  always_ff @(posedge clk) begin
    p1 <= fft_a;
    p2 <= p1;
    p3 <= p2;
  end
  assign fft_s = p3;

  int errors = 0;
  int checks = 0;
  int start_count = 0;
  int overlap_count = 0;

  always @(negedge clk) begin
    if (fft_start === 1'b1) start_count++;
    if (fft_start === 1'b1 && frame_done === 1'b1) overlap_count++;
  end

  logic [W-1:0]   fv [8];
  logic [W-1:0]   got [8];
  logic           got_last [8];
  logic [8*W-1:0] fa_hold;
  int             lat, hold_bad;
  logic           start_seen, inr_after, done_now, done_after, inr_now;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_idx(input int j);
    logic [2:0] b;
    b = 3'(j);
`ifdef FFT8_FRAME_CTRL_BITREV_EN
    return int'({b[0], b[1], b[2]});
`else
    return int'(b);
`endif
  endfunction

  // Feeds fv; leaves in_valid high with junk data so WAIT-phase storage would show up.
  task automatic feed(input int stall_after, input int stall_len);
    for (int i = 0; i < 8; i++) begin
      if (i == stall_after) begin
        in_valid = 1'b0;
        repeat (stall_len) step();
      end
      in_valid = 1'b1;
      in_data  = fv[i];
      for (int g = 0; g < 100 && !in_ready; g++) step();
      if (!in_ready) begin
        errors++;
        $display("FAIL feed_timeout: in_ready=%b required 1", in_ready);
      end
      step();
    end
    start_seen = fft_start;
    inr_after  = in_ready;
    in_data    = 16'hdead;
  endtask

  task automatic drain(input int bp_beat, input int bp_len);
    logic [W-1:0] v0;
    out_ready = 1'b1;
    hold_bad  = 0;
    lat       = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    in_valid = 1'b0;
    fa_hold  = fft_a;
    for (int j = 0; j < 8; j++) begin
      if (j == bp_beat) begin
        out_ready = 1'b0;
        v0 = out_data;
        for (int k = 0; k < bp_len; k++) begin
          step();
          if (out_data !== v0 || out_valid !== 1'b1) hold_bad++;
        end
        out_ready = 1'b1;
      end
      got[j]      = out_valid ? out_data : 'x;
      got_last[j] = out_last;
      step();
    end
    done_now   = frame_done;
    inr_now    = in_ready;
    step();
    done_after = frame_done;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i + 100);
      step();
    end
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({fft_a, fft_start, frame_done, out_valid, out_last, out_data, frame_cnt, in_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: fft_a=%h start=%b done=%b ov=%b last=%b od=%h cnt=%0d ir=%b required all 0",
               fft_a, fft_start, frame_done, out_valid, out_last, out_data, frame_cnt, in_ready);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    checks++;
    if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt); end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] cnt_exp);
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (got[j] !== fv[exp_idx(j)]) begin
        errors++;
        $display("FAIL %s_beat%0d: got %0d required %0d", tag, j, got[j], fv[exp_idx(j)]);
      end
      checks++;
      if (got_last[j] !== (j == 7)) begin
        errors++;
        $display("FAIL %s_last%0d: got %b required %b", tag, j, got_last[j], j == 7);
      end
    end
    checks++;
    if (done_now !== 1'b1 || done_after !== 1'b0) begin
      errors++;
      $display("FAIL %s_frame_done: got %b,%b required 1,0", tag, done_now, done_after);
    end
    checks++;
    if (inr_now !== 1'b1) begin errors++; $display("FAIL %s_in_ready_back: got %b required 1", tag, inr_now); end
    checks++;
    if (frame_cnt !== cnt_exp) begin
      errors++;
      $display("FAIL %s_frame_cnt: got %0d required %0d", tag, frame_cnt, cnt_exp);
    end
  endtask

  task automatic test_single_frame();
    fv = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80};
    start_count = 0;
    feed(8, 0);
    checks++;
    if (start_seen !== 1'b1) begin errors++; $display("FAIL single_fft_start: got %b required 1", start_seen); end
    checks++;
    if (inr_after !== 1'b0) begin errors++; $display("FAIL single_in_ready_drop: got %b required 0", inr_after); end
    drain(8, 0);
    checks++;
    if (lat !== PIPE_LAT + 1) begin errors++; $display("FAIL single_latency: got %0d required %0d", lat, PIPE_LAT + 1); end
    checks++;
    if (start_count !== 1) begin errors++; $display("FAIL single_start_pulses: got %0d required 1", start_count); end
    check_frame("single", 8'd1);
  endtask

  task automatic test_input_stall();
    logic [8*W-1:0] fa_exp;
    fv = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80};
    for (int k = 0; k < 8; k++) fa_exp[k*W +: W] = fv[k];
    feed(4, 3);
    drain(8, 0);
    checks++;
    if (fa_hold !== fa_exp) begin errors++; $display("FAIL stall_fft_a_hold: got %h required %h", fa_hold, fa_exp); end
    check_frame("stall", 8'd2);
  endtask

  task automatic test_backpressure();
    fv = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80};
    feed(8, 0);
    drain(2, 5);
    checks++;
    if (hold_bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d changes required 0", hold_bad); end
    check_frame("bp", 8'd3);
  endtask

  task automatic test_reset_mid_unload();
    fv = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80};
    feed(8, 0);
    out_ready = 1'b1;
    for (int g = 0; g < 50 && !out_valid; g++) step();
    in_valid = 1'b0;
    repeat (2) step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || frame_cnt !== 8'd0 || fft_a !== '0) begin
      errors++;
      $display("FAIL midreset_clear: ov=%b cnt=%0d fft_a=%h required 0,0,0", out_valid, frame_cnt, fft_a);
    end
    step();
    rst = 1'b0;
    step();
    fv = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    feed(8, 0);
    drain(8, 0);
    check_frame("midreset", 8'd1);
  endtask

  task automatic test_wrap();
    for (int f = 0; f < 254; f++) begin
      for (int k = 0; k < 8; k++) fv[k] = 16'(f * 8 + k);
      feed(8, 0);
      drain(8, 0);
    end
    checks++;
    if (frame_cnt !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d required 255", frame_cnt); end
    feed(8, 0);
    drain(8, 0);
    checks++;
    if (frame_cnt !== 8'd0) begin errors++; $display("FAIL wrap_0: got %0d required 0", frame_cnt); end
    checks++;
    if (overlap_count !== 0) begin errors++; $display("FAIL start_done_overlap: got %0d required 0", overlap_count); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_input_stall();
    test_backpressure();
    test_reset_mid_unload();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
